// File: rtl/pipe_ifid_pkg.sv
// Shared IF/ID pipeline definitions: datapath width defaults, the NOP value
// and the IF/ID buffer state encoding.
package pipe_ifid_pkg;

  localparam int INST_W_DEF = 32;
  localparam int PC_W_DEF   = 32;

  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;

  localparam logic [1:0] EMPTY_ENC = 2'd0;
  localparam logic [1:0] ONE_ENC   = 2'd1;
  localparam logic [1:0] TWO_ENC   = 2'd2;

  typedef enum logic [1:0] {
    EMPTY = EMPTY_ENC,
    ONE   = ONE_ENC,
    TWO   = TWO_ENC
  } ifid_state_e;

endpackage

// File: rtl/pipe_ifid_entry.sv
// One (inst, pc) storage slot of the IF/ID skid buffer.
// Loads on load=1 and clears asynchronously on clrn=0.
module pipe_ifid_entry
  import pipe_ifid_pkg::*;
#(
  parameter int INST_W = INST_W_DEF,
  parameter int PC_W   = PC_W_DEF
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              load,
  input  logic [INST_W-1:0] d_inst,
  input  logic [PC_W-1:0]   d_pc,
  output logic [INST_W-1:0] q_inst,
  output logic [PC_W-1:0]   q_pc
);

  logic [INST_W-1:0] inst_d, inst_q;
  logic [PC_W-1:0]   pc_d, pc_q;

  always_comb begin
    inst_d = inst_q;
    pc_d   = pc_q;
    if (load) begin
      inst_d = d_inst;
      pc_d   = d_pc;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      inst_q <= '0;
      pc_q   <= '0;
    end else begin
      inst_q <= inst_d;
      pc_q   <= pc_d;
    end
  end

  assign q_inst = inst_q;
  assign q_pc   = pc_q;

endmodule

// File: rtl/pipe_ifid_buffer.sv
// IF/ID 2-entry skid buffer (main + skid) with valid/ready on both sides.
// Optional stall/flush counters are built when PIPE_IFID_STALL_CNT_EN is defined.
module pipe_ifid_buffer
  import pipe_ifid_pkg::*;
#(
  parameter int                INST_W   = INST_W_DEF,
  parameter int                PC_W     = PC_W_DEF,
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(NOP_INST_DEF)
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              if_valid,
  input  logic [INST_W-1:0] if_inst,
  input  logic [PC_W-1:0]   if_pc,
  output logic              if_ready,
  output logic              id_valid,
  output logic [INST_W-1:0] id_inst,
  output logic [PC_W-1:0]   id_pc,
  input  logic              id_ready,
  input  logic              flush
`ifdef PIPE_IFID_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [15:0]       flush_cnt
`endif
);

  ifid_state_e state_d, state_q;

  logic              accept, consume;
  logic              main_load, main_from_skid, skid_load;
  logic [INST_W-1:0] main_inst, skid_inst, main_d_inst;
  logic [PC_W-1:0]   main_pc, skid_pc, main_d_pc;

  // Handshake outputs come only from registered state, never from id_ready.
  assign if_ready = (state_q != TWO);
  assign id_valid = (state_q != EMPTY);
  assign accept   = if_valid & if_ready;
  assign consume  = id_valid & id_ready;

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d   = ONE;
            main_load = 1'b1;
          end
        end
        ONE: begin
          if (accept && consume) begin
            main_load = 1'b1;
          end else if (accept) begin
            state_d   = TWO;
            skid_load = 1'b1;
          end else if (consume) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (consume) begin
            state_d        = ONE;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  assign main_d_inst = main_from_skid ? skid_inst : if_inst;
  assign main_d_pc   = main_from_skid ? skid_pc   : if_pc;

  pipe_ifid_entry #(.INST_W(INST_W), .PC_W(PC_W)) u_main (
    .clk    (clk),
    .clrn   (clrn),
    .load   (main_load),
    .d_inst (main_d_inst),
    .d_pc   (main_d_pc),
    .q_inst (main_inst),
    .q_pc   (main_pc)
  );

  pipe_ifid_entry #(.INST_W(INST_W), .PC_W(PC_W)) u_skid (
    .clk    (clk),
    .clrn   (clrn),
    .load   (skid_load),
    .d_inst (if_inst),
    .d_pc   (if_pc),
    .q_inst (skid_inst),
    .q_pc   (skid_pc)
  );

  assign id_inst = id_valid ? main_inst : NOP_INST;
  assign id_pc   = main_pc;

`ifdef PIPE_IFID_STALL_CNT_EN
  logic [31:0] stall_cnt_d, stall_cnt_q;
  logic [15:0] flush_cnt_d, flush_cnt_q;

  // Stall count wraps naturally; flush count saturates.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (id_valid && !id_ready && !flush)
      stall_cnt_d = stall_cnt_q + 32'd1;
    if (flush && (state_q != EMPTY) && (flush_cnt_q != 16'hFFFF))
      flush_cnt_d = flush_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule
